// File: rtl/ppu_scanline_buf.sv
// Double-buffered 256x6 scanline store between the PPU pixel pipeline and VGA scan-out.
// The PPU fills one bank while VGA reads the other; banks swap at the end of a visible read pass.
module ppu_scanline_buf #(
  parameter logic [5:0] BLANK_IDX = 6'h0F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ppu_clk_en,
  input  logic       ppu_pix_valid,
  input  logic [7:0] ppu_pix_x,
  input  logic [5:0] ppu_pix_idx,
  input  logic       ppu_line_done,
  input  logic       ppu_frame_start,
  input  logic [7:0] vga_buf_idx,
  output logic [5:0] vga_buf_out,
  output logic       wr_bank,
  output logic       line_overflow
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned COL_W = 8;
  localparam int unsigned DEPTH = 256;
  localparam logic [COL_W-1:0] LAST_VIS_COL = COL_W'(255);

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_t;

  wr_state_t        state;
  logic [1:0]       bank_valid;
  logic [COL_W-1:0] prev_idx;
  logic [IDX_W-1:0] mem [2][DEPTH];

  logic pass_end;
  logic ppu_pix;
  logic ppu_done;
  logic mem_we;
  logic ovf_set;
  logic ovf_clr;
  logic rd_bank;

  // A pass ends only on the 255->256 column step; the 340->0 wrap never reads as 255->0.
  always_comb begin
    pass_end = (prev_idx == LAST_VIS_COL) && (vga_buf_idx == COL_W'(0));
    ppu_pix  = ppu_clk_en & ppu_pix_valid;
    ppu_done = ppu_clk_en & ppu_line_done;
    mem_we   = ppu_pix & (state == WR_FILL);
    ovf_set  = (state == WR_WAIT) & (ppu_pix | ppu_done);
    ovf_clr  = ppu_clk_en & ppu_frame_start;
    rd_bank  = ~wr_bank;
  end

  // Write-side FSM, bank bookkeeping and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WR_FILL;
      wr_bank       <= 1'b0;
      bank_valid    <= 2'b00;
      prev_idx      <= '0;
      line_overflow <= 1'b0;
    end else begin
      prev_idx <= vga_buf_idx;
      case (state)
        WR_FILL: begin
          if (ppu_done) begin
            bank_valid[wr_bank] <= 1'b1;
            state               <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (pass_end) begin
            wr_bank <= ~wr_bank;
            state   <= WR_FILL;
          end
        end
      endcase
      if (ovf_set) begin
        line_overflow <= 1'b1;
      end else if (ovf_clr) begin
        line_overflow <= 1'b0;
      end
    end
  end

  // Pixel storage is deliberately left unreset; bank_valid gates what the reader sees.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_bank][ppu_pix_x] <= ppu_pix_idx;
    end
  end

  always_comb begin
    vga_buf_out = BLANK_IDX;
    if (bank_valid[rd_bank]) begin
      vga_buf_out = mem[rd_bank][vga_buf_idx];
    end
  end

endmodule

// File: tb/tb_ppu_scanline_buf.sv
// Scoreboard bench for ppu_scanline_buf: read expectations are queued when a column is driven
// and popped when the combinational output is sampled.
module tb_ppu_scanline_buf;

  logic       clk;
  logic       rst_n;
  logic       ppu_clk_en;
  logic       ppu_pix_valid;
  logic [7:0] ppu_pix_x;
  logic [5:0] ppu_pix_idx;
  logic       ppu_line_done;
  logic       ppu_frame_start;
  logic [7:0] vga_buf_idx;
  logic [5:0] vga_buf_out;
  logic       wr_bank;
  logic       line_overflow;

  int n_checks;
  int n_errors;
  logic [5:0] exp_q [$];

  ppu_scanline_buf #(.BLANK_IDX(6'h0F)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ppu_clk_en      (ppu_clk_en),
    .ppu_pix_valid   (ppu_pix_valid),
    .ppu_pix_x       (ppu_pix_x),
    .ppu_pix_idx     (ppu_pix_idx),
    .ppu_line_done   (ppu_line_done),
    .ppu_frame_start (ppu_frame_start),
    .vga_buf_idx     (vga_buf_idx),
    .vga_buf_out     (vga_buf_out),
    .wr_bank         (wr_bank),
    .line_overflow   (line_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PPU enable slot; all strobes drop again after the edge.
  task automatic ppu_cycle(input logic en, input logic valid, input logic [7:0] x,
                           input logic [5:0] idx, input logic done, input logic fs);
    ppu_clk_en      = en;
    ppu_pix_valid   = valid;
    ppu_pix_x       = x;
    ppu_pix_idx     = idx;
    ppu_line_done   = done;
    ppu_frame_start = fs;
    tick();
    ppu_clk_en      = 1'b0;
    ppu_pix_valid   = 1'b0;
    ppu_line_done   = 1'b0;
    ppu_frame_start = 1'b0;
  endtask

  task automatic fill(input logic use_x, input logic [5:0] c, input int lo, input int hi,
                      input logic done_last);
    for (int x = lo; x <= hi; x++) begin
      ppu_cycle(1'b1, 1'b1, 8'(x), use_x ? 6'(x) : c, done_last && (x == hi), 1'b0);
    end
  endtask

  task automatic read_chk(input string tag, input logic [7:0] col, input logic [5:0] exp);
    logic [5:0] e;
    vga_buf_idx = col;
    exp_q.push_back(exp);
    #2;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty at col %0d", tag, col);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(vga_buf_out), 32'(e));
    end
    tick();
  endtask

  task automatic read_sweep(input string tag, input logic use_x, input logic [5:0] c);
    for (int i = 0; i < 256; i++) begin
      read_chk(tag, 8'(i), use_x ? 6'(i) : c);
    end
  endtask

  task automatic set_col(input logic [7:0] col);
    vga_buf_idx = col;
    tick();
  endtask

  task automatic pass_end_sweep();
    set_col(8'd254);
    set_col(8'd255);
    set_col(8'd0);
    vga_buf_idx = 8'd100;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    ppu_clk_en      = 1'b0;
    ppu_pix_valid   = 1'b0;
    ppu_pix_x       = 8'd0;
    ppu_pix_idx     = 6'd0;
    ppu_line_done   = 1'b0;
    ppu_frame_start = 1'b0;
    vga_buf_idx     = 8'd100;

    // Reset state
    tick();
    tick();
    read_chk("rst_out_in_reset", 8'd37, 6'h0F);
    rst_n = 1'b1;
    tick();
    check("rst_wr_bank", 32'(wr_bank), 32'd0);
    check("rst_ovf", 32'(line_overflow), 32'd0);
    read_sweep("rst_sweep", 1'b0, 6'h0F);
    vga_buf_idx = 8'd100;

    // Bank 0 gets x[5:0]; last write coincides with line_done
    fill(1'b1, 6'h00, 0, 255, 1'b1);
    check("fill0_wr_bank", 32'(wr_bank), 32'd0);
    read_chk("fill0_not_visible", 8'd7, 6'h0F);
    ppu_cycle(1'b0, 1'b1, 8'd7, 6'h3F, 1'b1, 1'b0);
    check("en0_no_ovf", 32'(line_overflow), 32'd0);
    set_col(8'd84);
    set_col(8'd0);
    vga_buf_idx = 8'd100;
    check("col_wrap_no_swap", 32'(wr_bank), 32'd0);
    read_chk("col_wrap_still_blank", 8'd3, 6'h0F);
    pass_end_sweep();
    check("swap0_wr_bank", 32'(wr_bank), 32'd1);
    read_sweep("bank0_x", 1'b1, 6'h00);
    vga_buf_idx = 8'd100;

    // Bank 1 gets 0x2C; line_done lands together with pass_end
    fill(1'b0, 6'h2C, 0, 255, 1'b0);
    ppu_cycle(1'b0, 1'b1, 8'd9, 6'h3F, 1'b0, 1'b0);
    set_col(8'd254);
    set_col(8'd255);
    vga_buf_idx = 8'd0;
    ppu_cycle(1'b1, 1'b0, 8'd0, 6'd0, 1'b1, 1'b0);
    vga_buf_idx = 8'd100;
    check("done_with_pass_end_no_swap", 32'(wr_bank), 32'd1);
    check("done_with_pass_end_ovf", 32'(line_overflow), 32'd0);

    // Traffic while waiting is dropped and flagged
    ppu_cycle(1'b1, 1'b1, 8'd5, 6'h2A, 1'b0, 1'b0);
    check("ovf_set", 32'(line_overflow), 32'd1);
    read_chk("ovf_read_bank_intact", 8'd5, 6'h05);
    ppu_cycle(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(line_overflow), 32'd0);
    ppu_cycle(1'b1, 1'b0, 8'd0, 6'd0, 1'b1, 1'b1);
    check("ovf_set_wins", 32'(line_overflow), 32'd1);
    ppu_cycle(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 1'b1);
    check("ovf_cleared_again", 32'(line_overflow), 32'd0);
    check("ovf_no_swap", 32'(wr_bank), 32'd1);
    pass_end_sweep();
    check("swap1_wr_bank", 32'(wr_bank), 32'd0);
    read_sweep("bank1_2c", 1'b0, 6'h2C);
    vga_buf_idx = 8'd100;

    // Two lines 0x11 then 0x22 with interleaved passes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst2_wr_bank", 32'(wr_bank), 32'd0);
    read_chk("rst2_blank", 8'd5, 6'h0F);
    vga_buf_idx = 8'd100;
    fill(1'b0, 6'h11, 0, 255, 1'b1);
    pass_end_sweep();
    check("line11_swap", 32'(wr_bank), 32'd1);
    fill(1'b0, 6'h22, 0, 127, 1'b0);
    read_sweep("pass1_11", 1'b0, 6'h11);
    set_col(8'd0);
    vga_buf_idx = 8'd100;
    check("pass1_fill_no_swap", 32'(wr_bank), 32'd1);
    fill(1'b0, 6'h22, 128, 255, 1'b1);
    read_sweep("pass2_11", 1'b0, 6'h11);
    set_col(8'd0);
    vga_buf_idx = 8'd100;
    check("line22_swap", 32'(wr_bank), 32'd0);
    read_sweep("pass3_22", 1'b0, 6'h22);
    vga_buf_idx = 8'd100;

    // Asynchronous reset mid-line
    fill(1'b0, 6'h33, 0, 99, 1'b0);
    read_chk("pre_rst_22", 8'd10, 6'h22);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(vga_buf_out), 32'h0F);
    check("async_rst_wr_bank", 32'(wr_bank), 32'd0);
    check("async_rst_ovf", 32'(line_overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
